// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register bank: carries the decoded control bundle, operands, immediate
// and register indices from decode to execute through DEPTH retiming stages. It also
// supports stall (hold), flush (bubble), a valid bit, and load-use hazard detection.
// Optional macro ID_EX_PERF_COUNTERS_EN adds saturating stall/flush event counters.
module id_ex_pipeline_register #(
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned CTRL_W       = 8,
   parameter int unsigned REG_ADDR_W   = 5,
   parameter int unsigned DEPTH        = 1,
   parameter int unsigned MEM_READ_BIT = 3,
   parameter int unsigned COUNT_W      = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  stall_in,
   input  logic                  flush_in,
   input  logic                  valid_in,
   input  logic [CTRL_W-1:0]     ctrl_in,
   input  logic [DATA_W-1:0]     data_a_in,
   input  logic [DATA_W-1:0]     data_b_in,
   input  logic [DATA_W-1:0]     imm_in,
   input  logic [REG_ADDR_W-1:0] rs_in,
   input  logic [REG_ADDR_W-1:0] rt_in,
   input  logic [REG_ADDR_W-1:0] rd_in,
   output logic                  valid_out,
   output logic [CTRL_W-1:0]     ctrl_out,
   output logic [DATA_W-1:0]     data_a_out,
   output logic [DATA_W-1:0]     data_b_out,
   output logic [DATA_W-1:0]     imm_out,
   output logic [REG_ADDR_W-1:0] rs_out,
   output logic [REG_ADDR_W-1:0] rt_out,
   output logic [REG_ADDR_W-1:0] rd_out,
   output logic                  stall_req_out
`ifdef ID_EX_PERF_COUNTERS_EN
   ,
   output logic [COUNT_W-1:0]    stall_count_out,
   output logic [COUNT_W-1:0]    flush_count_out
`endif
);

   // Parameter legality is checked at elaboration so a bad configuration never builds.
   if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
      $error("id_ex_pipeline_register: DEPTH must be in 1..4");
   end
   if (MEM_READ_BIT >= CTRL_W) begin : g_bad_mem_read_bit
      $error("id_ex_pipeline_register: MEM_READ_BIT must be below CTRL_W");
   end
   if (COUNT_W < 1) begin : g_bad_count_w
      $error("id_ex_pipeline_register: COUNT_W must be at least 1");
   end

   typedef struct packed {
      logic                  valid;
      logic [CTRL_W-1:0]     ctrl;
      logic [DATA_W-1:0]     data_a;
      logic [DATA_W-1:0]     data_b;
      logic [DATA_W-1:0]     imm;
      logic [REG_ADDR_W-1:0] rs;
      logic [REG_ADDR_W-1:0] rt;
      logic [REG_ADDR_W-1:0] rd;
   } stage_t;

   stage_t r_stage [DEPTH];
   stage_t w_load;
   stage_t w_ex;

   // Build the word captured by stage0; a non-valid instruction never carries control.
   always_comb begin
      w_load        = '0;
      w_load.valid  = valid_in;
      w_load.ctrl   = valid_in ? ctrl_in : '0;
      w_load.data_a = data_a_in;
      w_load.data_b = data_b_in;
      w_load.imm    = imm_in;
      w_load.rs     = rs_in;
      w_load.rt     = rt_in;
      w_load.rd     = rd_in;
   end

   // Stage shift with priority reset > flush > stall > load.
   always_ff @(posedge clock) begin
      if (reset || flush_in) begin
         for (int k = 0; k < int'(DEPTH); k++) begin
            r_stage[k] <= '0;
         end
      end else if (!stall_in) begin
         r_stage[0] <= w_load;
         for (int k = 1; k < int'(DEPTH); k++) begin
            r_stage[k] <= r_stage[k-1];
         end
      end
   end

   // EX-side outputs come from the last stage.
   always_comb begin
      w_ex       = r_stage[DEPTH-1];
      valid_out  = w_ex.valid;
      ctrl_out   = w_ex.ctrl;
      data_a_out = w_ex.data_a;
      data_b_out = w_ex.data_b;
      imm_out    = w_ex.imm;
      rs_out     = w_ex.rs;
      rt_out     = w_ex.rt;
      rd_out     = w_ex.rd;
   end

   // Load-use hazard: a valid load in EX whose destination rt feeds the ID instruction.
   always_comb begin
      stall_req_out = !reset && w_ex.valid && w_ex.ctrl[MEM_READ_BIT] &&
                      (w_ex.rt != '0) && ((w_ex.rt == rs_in) || (w_ex.rt == rt_in));
   end

`ifdef ID_EX_PERF_COUNTERS_EN
   logic [COUNT_W-1:0] r_stall_cnt;
   logic [COUNT_W-1:0] r_flush_cnt;

   // Saturating event counters; a stall that coincides with a flush is not a stall.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (stall_in && !flush_in && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + COUNT_W'(1);
         end
         if (flush_in && (r_flush_cnt != '1)) begin
            r_flush_cnt <= r_flush_cnt + COUNT_W'(1);
         end
      end
   end

   assign stall_count_out = r_stall_cnt;
   assign flush_count_out = r_flush_cnt;
`endif

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Bench for id_ex_pipeline_register: a DEPTH=1 and a DEPTH=3 instance share one stimulus
// stream and are compared against a queue-based model of the pipeline contents.
module tb_id_ex_pipeline_register;

   typedef struct packed {
      logic        v;
      logic [7:0]  c;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] i;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
   } word_t;

   logic        clock = 1'b0;
   logic        reset, stall_in, flush_in, valid_in;
   logic [7:0]  ctrl_in;
   logic [31:0] data_a_in, data_b_in, imm_in;
   logic [4:0]  rs_in, rt_in, rd_in;

   logic        valid_out_1, valid_out_3, stall_req_1, stall_req_3;
   logic [7:0]  ctrl_out_1, ctrl_out_3;
   logic [31:0] data_a_out_1, data_b_out_1, imm_out_1;
   logic [31:0] data_a_out_3, data_b_out_3, imm_out_3;
   logic [4:0]  rs_out_1, rt_out_1, rd_out_1, rs_out_3, rt_out_3, rd_out_3;
`ifdef ID_EX_PERF_COUNTERS_EN
   logic [3:0]  stall_cnt_1, flush_cnt_1;
   logic [15:0] stall_cnt_3, flush_cnt_3;
`endif

   int n_vec = 0;
   int n_err = 0;
   word_t q1[$];
   word_t q3[$];
   int    m_stall_cnt = 0;
   int    m_flush_cnt = 0;

   always #5 clock = ~clock;

   id_ex_pipeline_register #(.DEPTH(1), .COUNT_W(4)) dut1 (
      .clock(clock), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
      .valid_in(valid_in), .ctrl_in(ctrl_in), .data_a_in(data_a_in), .data_b_in(data_b_in),
      .imm_in(imm_in), .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
      .valid_out(valid_out_1), .ctrl_out(ctrl_out_1), .data_a_out(data_a_out_1),
      .data_b_out(data_b_out_1), .imm_out(imm_out_1), .rs_out(rs_out_1), .rt_out(rt_out_1),
      .rd_out(rd_out_1), .stall_req_out(stall_req_1)
`ifdef ID_EX_PERF_COUNTERS_EN
      , .stall_count_out(stall_cnt_1), .flush_count_out(flush_cnt_1)
`endif
   );

   id_ex_pipeline_register #(.DEPTH(3)) dut3 (
      .clock(clock), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
      .valid_in(valid_in), .ctrl_in(ctrl_in), .data_a_in(data_a_in), .data_b_in(data_b_in),
      .imm_in(imm_in), .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
      .valid_out(valid_out_3), .ctrl_out(ctrl_out_3), .data_a_out(data_a_out_3),
      .data_b_out(data_b_out_3), .imm_out(imm_out_3), .rs_out(rs_out_3), .rt_out(rt_out_3),
      .rd_out(rd_out_3), .stall_req_out(stall_req_3)
`ifdef ID_EX_PERF_COUNTERS_EN
      , .stall_count_out(stall_cnt_3), .flush_count_out(flush_cnt_3)
`endif
   );

   task automatic chk(input string tag, input logic [119:0] obs, input logic [119:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Hazard rule evaluated on the instruction the model says is in EX.
   function automatic logic hazard(input word_t e);
      return !reset && e.v && e.c[3] && (e.rt != 5'd0) && ((e.rt == rs_in) || (e.rt == rt_in));
   endfunction

   task automatic check_all();
      chk("word_d1", {valid_out_1, ctrl_out_1, data_a_out_1, data_b_out_1, imm_out_1,
                      rs_out_1, rt_out_1, rd_out_1}, q1[$]);
      chk("word_d3", {valid_out_3, ctrl_out_3, data_a_out_3, data_b_out_3, imm_out_3,
                      rs_out_3, rt_out_3, rd_out_3}, q3[$]);
      chk("hazard_d1", 120'(stall_req_1), 120'(hazard(q1[$])));
      chk("hazard_d3", 120'(stall_req_3), 120'(hazard(q3[$])));
`ifdef ID_EX_PERF_COUNTERS_EN
      chk("stall_cnt_d1", 120'(stall_cnt_1), 120'((m_stall_cnt > 15) ? 15 : m_stall_cnt));
      chk("flush_cnt_d1", 120'(flush_cnt_1), 120'((m_flush_cnt > 15) ? 15 : m_flush_cnt));
      chk("stall_cnt_d3", 120'(stall_cnt_3), 120'(m_stall_cnt));
      chk("flush_cnt_d3", 120'(flush_cnt_3), 120'(m_flush_cnt));
`endif
   endtask

   // Drive one cycle of inputs, advance the model, then check #1 after the edge.
   task automatic step(input logic rst, input logic st, input logic fl, input logic vld,
                       input logic [7:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd);
      word_t nw;
      reset = rst; stall_in = st; flush_in = fl; valid_in = vld; ctrl_in = c;
      data_a_in = a; data_b_in = b; imm_in = im; rs_in = rs; rt_in = rt; rd_in = rd;
      nw = '{v: vld, c: (vld ? c : 8'h00), a: a, b: b, i: im, rs: rs, rt: rt, rd: rd};
      if (rst || fl) begin
         foreach (q1[k]) q1[k] = '0;
         foreach (q3[k]) q3[k] = '0;
      end else if (!st) begin
         q1.push_front(nw); void'(q1.pop_back());
         q3.push_front(nw); void'(q3.pop_back());
      end
      if (rst) begin
         m_stall_cnt = 0; m_flush_cnt = 0;
      end else begin
         if (st && !fl) m_stall_cnt++;
         if (fl) m_flush_cnt++;
      end
      @(posedge clock);
      #1;
      check_all();
   endtask

   task automatic rnd_step(input logic st, input logic fl, input logic vld);
      step(1'b0, st, fl, vld, 8'($urandom), $urandom, $urandom, $urandom,
           5'($urandom), 5'($urandom), 5'($urandom));
   endtask

   initial begin
      q1.push_back('0);
      repeat (3) q3.push_back('0);

      // Reset held with every input at its maximum.
      repeat (2) step(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, '1, '1, '1, '1, '1, '1);
      chk("reset_zero_d1", {valid_out_1, ctrl_out_1, data_a_out_1, stall_req_1}, 120'd0);
      rnd_step(1'b0, 1'b0, 1'b1);

      // Latency: a single marked word followed by bubbles.
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 32'h0000_00A5, $urandom, $urandom, 5'd1, 5'd2, 5'd3);
      chk("lat_d1_a", 120'(data_a_out_1), 120'h0A5);
      repeat (4) rnd_step(1'b0, 1'b0, 1'b0);

      // Stall holds ctrl 0x5A while inputs keep changing.
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, $urandom, $urandom, $urandom, 5'd4, 5'd5, 5'd6);
      repeat (4) rnd_step(1'b1, 1'b0, 1'b1);
      chk("stall_hold_d1", 120'(ctrl_out_1), 120'h5A);
      rnd_step(1'b0, 1'b0, 1'b1);
      repeat (3) rnd_step(1'b0, 1'b0, 1'b1);

      // Flush beats stall and discards a valid ID instruction.
      step(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, '1, '1, '1, '1, '1, '1);
      chk("flush_bubble_d1", {valid_out_1, ctrl_out_1}, 120'd0);

      // Load-use hazard cases, observed while stalled so EX is stable.
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h08, $urandom, $urandom, $urandom, 5'd9, 5'd5, 5'd7);
      step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, $urandom, $urandom, $urandom, 5'd5, 5'd3, 5'd0);
      chk("hazard_hit_d1", 120'(stall_req_1), 120'd1);
      step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, $urandom, $urandom, $urandom, 5'd3, 5'd5, 5'd0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h08, $urandom, $urandom, $urandom, 5'd9, 5'd0, 5'd7);
      step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, $urandom, $urandom, $urandom, 5'd0, 5'd0, 5'd0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'hF7, $urandom, $urandom, $urandom, 5'd9, 5'd5, 5'd7);
      step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, $urandom, $urandom, $urandom, 5'd5, 5'd5, 5'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h08, $urandom, $urandom, $urandom, 5'd9, 5'd5, 5'd7);
      step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, $urandom, $urandom, $urandom, 5'd5, 5'd5, 5'd0);

      // Counter saturation and clearing.
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, '0, '0, '0, '0, '0, '0);
      repeat (20) rnd_step(1'b1, 1'b0, 1'b1);
      repeat (3) rnd_step(1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, '0, '0, '0, '0, '0, '0);

      // Randomized traffic with small register indices to provoke hazards often.
      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 25),
              ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 70),
              8'($urandom) | 8'(($urandom_range(0, 1)) << 3), $urandom, $urandom, $urandom,
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
